// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor controller.
//   - state_t          : controller state encoding (IDLE/SHIFT/DONE)
//   - SUB_WIDTH_DEFAULT: default operand/result width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: one-bit full subtractor built from two half subtractors
// plus an OR gate. Purely combinational.
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in
//   d     : difference bit  = a ^ b ^ bin
//   bout  : borrow out
// Also holds HalfSubtractor: d = a ^ b, bo = ~a & b.

module HalfSubtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);
    assign d  = a ^ b;
    assign bo = ~a & b;
endmodule

module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    HalfSubtractor u_hs0 (.a(a),    .b(b),   .d(w_d1), .bo(w_b1));
    HalfSubtractor u_hs1 (.a(w_d1), .b(bin), .d(d),    .bo(w_b2));

    assign bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor controller. One
// full_sub_cell is reused for every bit, LSB first, one bit per clock.
//   i_clk        : rising-edge clock
//   i_reset      : synchronous active-high reset
//   i_start      : request, sampled only in IDLE
//   i_a, i_b     : minuend / subtrahend, captured on accepted start
//   o_busy       : high while bits are being processed
//   o_done       : one-cycle pulse when results update
//   o_diff       : A - B mod 2^WIDTH, held until the next done
//   o_borrow_out : final borrow (A < B unsigned)
//   o_overflow   : signed overflow; built only with SERIAL_SUB_OVERFLOW_EN,
//                  otherwise tied to 0
// Timing: accept at edge 0, busy after edges 1..WIDTH, done and results
// after edge WIDTH+1. Busy/done are registered from the state, so they lag
// the state register by one cycle.

module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out,
    output logic             o_overflow
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;

    logic w_d;
    logic w_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Captured sign bits: [1] = A MSB, [0] = B MSB.
    logic [1:0] r_sign;
`else
    assign o_overflow = 1'b0;
`endif

    full_sub_cell u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_diff       <= '0;
            o_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_sign       <= 2'b00;
            o_overflow   <= 1'b0;
`endif
        end else begin
            o_busy <= (r_state == ST_SHIFT);
            o_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a_sh   <= i_a;
                        r_b_sh   <= i_b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        r_sign   <= {i_a[WIDTH-1], i_b[WIDTH-1]};
`endif
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Result fills from the top so after WIDTH shifts bit 0
                    // of the operands lands in bit 0 of the result.
                    r_res    <= {w_d, r_res[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_borrow <= w_bout;
                    if (r_cnt == LAST_BIT) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    o_diff       <= r_res;
                    o_borrow_out <= r_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    o_overflow   <= (r_sign[1] != r_sign[0]) &&
                                    (r_res[WIDTH-1] != r_sign[1]);
`endif
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, bo, ovf;
    logic [W-1:0] diff;

    int n_chk  = 0;
    int n_pass = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_a(a), .i_b(b),
        .o_busy(busy), .o_done(done), .o_diff(diff),
        .o_borrow_out(bo), .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: plain modular arithmetic on integers.
    function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned r;
        r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        return r[W-1:0];
    endfunction

    function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_SUB_OVERFLOW_EN
        int sx, sy, sd;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        sd = sx - sy;
        return (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
`else
        return (x != x);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation and gathers observations (no checking here).
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output int busy_cnt, output int done_at,
                         output logic [W-1:0] od, output logic obo, output logic oov);
        start = 1'b1; a = xa; b = xb;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        busy_cnt = 0; done_at = 0; od = 'x; obo = 1'bx; oov = 1'bx;
        for (int k = 1; k <= W + 3; k++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_at = k; od = diff; obo = bo; oov = ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        n_chk++;
        if ({busy, done, diff, bo, ovf} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0",
                     busy, done, diff, bo, ovf);
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] va[6] = '{8'h5A, 8'h10, 8'h00, 8'hFF, 8'h80, 8'h7F};
        logic [W-1:0] vb[6] = '{8'h23, 8'h20, 8'h01, 8'hFF, 8'h01, 8'hFF};
        int bc, da; logic [W-1:0] d; logic xb, xo;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], bc, da, d, xb, xo);
            n_chk++;
            if (bc !== W || da !== W + 1) $display("FAIL dir_timing[%0d]: busy_cycles=%0d done_at=%0d, want %0d/%0d", i, bc, da, W, W + 1);
            else n_pass++;
            n_chk++;
            if (d !== m_diff(va[i], vb[i])) $display("FAIL dir_diff[%0d]: got %h want %h", i, d, m_diff(va[i], vb[i]));
            else n_pass++;
            n_chk++;
            if (xb !== m_borrow(va[i], vb[i])) $display("FAIL dir_borrow[%0d]: got %b want %b", i, xb, m_borrow(va[i], vb[i]));
            else n_pass++;
            n_chk++;
            if (xo !== m_ovf(va[i], vb[i])) $display("FAIL dir_ovf[%0d]: got %b want %b", i, xo, m_ovf(va[i], vb[i]));
            else n_pass++;
        end
        // Done must be a single-cycle pulse.
        tick();
        n_chk++;
        if (done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", done);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int dcount = 0; logic [W-1:0] dval = '0;
        start = 1'b1; a = 8'h05; b = 8'h03;
        tick();
        a = 8'h99;  // Start stays high through SHIFT and DONE
        for (int k = 1; k <= W + 1; k++) begin
            tick();
            if (done) begin dcount++; dval = diff; end
        end
        start = 1'b0;
        n_chk++;
        if (dcount !== 1 || dval !== 8'h02) $display("FAIL ignore_start_result: dones=%0d diff=%h, want 1/02", dcount, dval);
        else n_pass++;
        for (int k = 0; k < 4; k++) tick();
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h02) $display("FAIL ignore_start_idle: busy=%b done=%b diff=%h, want 0/0/02", busy, done, diff);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bc, da, dseen = 0; logic [W-1:0] d; logic xb, xo;
        start = 1'b1; a = 8'hC3; b = 8'h11;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        n_chk++;
        if ({busy, done, diff, bo, ovf} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0})
            $display("FAIL reset_mid_outputs: busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0", busy, done, diff, bo, ovf);
        else n_pass++;
        reset = 1'b0;
        for (int k = 0; k < W + 4; k++) begin tick(); if (done || busy) dseen++; end
        n_chk++;
        if (dseen !== 0) $display("FAIL reset_mid_no_done: activity cycles=%0d want 0", dseen);
        else n_pass++;
        do_op(8'h40, 8'h01, bc, da, d, xb, xo);
        n_chk++;
        if (da !== W + 1 || d !== 8'h3F || xb !== 1'b0) $display("FAIL after_reset_op: done_at=%0d diff=%h bo=%b, want %0d/3f/0", da, d, xb, W + 1);
        else n_pass++;
    endtask

    task automatic test_random();
        int bc, da; logic [W-1:0] ra, rb, d; logic xb, xo;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            do_op(ra, rb, bc, da, d, xb, xo);
            n_chk++;
            if (bc !== W || da !== W + 1 || d !== m_diff(ra, rb) || xb !== m_borrow(ra, rb) || xo !== m_ovf(ra, rb))
                $display("FAIL rand[%0d] %h-%h: busy=%0d done_at=%0d diff=%h bo=%b ovf=%b, want %0d/%0d/%h/%b/%b",
                         i, ra, rb, bc, da, d, xb, xo, W, W + 1, m_diff(ra, rb), m_borrow(ra, rb), m_ovf(ra, rb));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int dcount = 0, last = -1, bad_gap = 0, bad_diff = 0;
        start = 1'b1; a = 8'h0C; b = 8'h04;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                if (last >= 0 && k - last != W + 2) bad_gap++;
                if (diff !== 8'h08) bad_diff++;
                last = k; dcount++;
            end
        end
        start = 1'b0;
        n_chk++;
        if (dcount !== 4) $display("FAIL b2b_done_count: got %0d want 4", dcount);
        else n_pass++;
        n_chk++;
        if (bad_gap !== 0 || bad_diff !== 0) $display("FAIL b2b_spacing: bad_gaps=%0d bad_diffs=%0d want 0/0", bad_gap, bad_diff);
        else n_pass++;
        for (int k = 0; k < W + 3; k++) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial N-bit subtractor controller. It sequences a single one-bit full-subtract cell, built from two half-subtractor cells, over a WIDTH-bit operand pair, one bit per clock, LSB first. A Start/Busy/Done handshake makes it the area-minimal subtract resource for the board-level demo datapaths, in place of a ripple-chain of WIDTH cells.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high; clears all state and outputs.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on accepted Start.
- B  input  WIDTH  subtrahend; captured on accepted Start.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse when Diff/BorrowOut are updated.
- Diff  output  WIDTH  A - B modulo 2^WIDTH; held until next Done.
- BorrowOut  output  1  final borrow, 1 when A < B unsigned.
- Overflow  output  1  signed overflow flag (see Configuration).

One clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on Start=1.
  - SHIFT -> DONE when the bit counter equals WIDTH-1.
  - DONE -> IDLE unconditionally.
- Accept in IDLE:
  - Latch A and B into shift registers.
  - Clear the borrow register.
  - Clear the bit counter.
- SHIFT, one bit per cycle, with a = A_sh[0], b = B_sh[0], bin = borrow register:
  - First half-subtract: d1 = a^b, b1 = ~a&b.
  - Second half-subtract: d = d1^bin, b2 = ~d1&bin.
  - Next borrow = b1|b2.
  - Shift d into the MSB of the result shift register.
  - Shift A_sh and B_sh right.
  - Increment the counter.
- Entering DONE:
  - Diff <= result register, including the final bit.
  - BorrowOut <= final borrow.
  - Overflow updated.
  - Done=1 for exactly the DONE cycle.
- Start is ignored in SHIFT and DONE. No queuing; operands on A/B are don't-care outside the accept cycle.
- Diff, BorrowOut and Overflow keep their previous values during SHIFT.
- Counter width is $clog2(WIDTH). The counter does not wrap within an operation and is cleared on accept.

## Timing
- Reset values: state=IDLE, Busy=0, Done=0, Diff=0, BorrowOut=0, Overflow=0, internal registers 0.
- Start accepted at edge 0. Busy=1 after edges 1..WIDTH (SHIFT occupies WIDTH cycles).
- Done=1 and new results visible after edge WIDTH+1. Busy=0 in that cycle.
- Next Start is accepted at edge WIDTH+2 at the earliest, giving a minimum initiation interval of WIDTH+2 cycles.
- Reset mid-operation has priority over everything:
  - Returns to IDLE at the next edge, with all outputs at reset values.
  - The in-flight operation is discarded and no Done is issued.
- Start held high continuously: a new operation starts each time IDLE is re-entered.

## Configuration
- Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: Overflow = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]), two's-complement interpretation.
  - Uses the captured A/B sign bits, kept in a 2-bit register.
  - Registered with Diff on DONE entry.
- Undefined: Overflow is tied to 0, the sign register is not built, and the port remains for a stable interface.

## Structure
- Shared package/header serial_sub_pkg: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
- One sub-module, full_sub_cell:
  - Ports: a, b, bin in; d, bout out.
  - Purely combinational, built from two HalfSubtractor instances plus an OR gate.
  - Instantiated once in the controller.

## Test plan
All cases use WIDTH=8.
- A=0x5A, B=0x23, Start pulse -> Busy high for 8 cycles, Done on the 9th cycle after accept; Diff=0x37, BorrowOut=0.
- A=0x10, B=0x20 -> Diff=0xF0, BorrowOut=1. Then A=0x00, B=0x01 -> Diff=0xFF, BorrowOut=1. Then A=0xFF, B=0xFF -> Diff=0x00, BorrowOut=0.
- A=0x05, B=0x03 accepted, then Start=1 with A=0x99 during SHIFT and DONE -> ignored; Diff=0x02. Next op starts only from IDLE.
- Reset asserted 4 cycles into SHIFT -> all outputs 0, no Done. Then A=0x40, B=0x01 -> Diff=0x3F, BorrowOut=0.
- A=0x80, B=0x01 -> Diff=0x7F, BorrowOut=0; Overflow=1 with SERIAL_SUB_OVERFLOW_EN, 0 without. Also A=0x7F, B=0xFF -> Diff=0x80, Overflow=1 with macro.
- Start held high for 40 cycles with A=0x0C, B=0x04 -> a Done pulse every 10 cycles, Diff=0x08 each time.
